// File: rtl/spi_master.sv
// Mode-0 SPI master, 8-bit MSB-first full duplex to one of three slaves; done at 18*CLK_DIV+1 cycles after start.
// Start is ignored while busy (no queueing); select index 3 is rejected outright.
module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] slave_sel,
  input  logic [7:0] tx_data,
  input  logic       miso,
  output logic       sclk,
  output logic [2:0] ss,
  output logic       mosi,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       done
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [3:0]    phase;
  logic [6:0]    tx_sr;
  logic [7:0]    rx_sr;
  logic          phase_end;
  logic          accept;

  logic          sclk_nxt, mosi_nxt, busy_nxt, done_nxt;
  logic [2:0]    ss_nxt;
  logic          load_tx, shift_tx, sample_rx, load_rx;

  assign phase_end = (cnt == CNT_MAX);
  assign accept    = (state == IDLE) && start && (slave_sel != 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   if (phase_end) state_nxt = XFER;
      XFER:    if (phase_end && phase == 4'd15) state_nxt = HOLD;
      HOLD:    if (phase_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // XFER spans 16 half-periods: sclk is high in even phases, and the final
  // low phase (15) plus HOLD give the 2*CLK_DIV tail before ss releases.
  always_comb begin
    sclk_nxt  = sclk;
    ss_nxt    = ss;
    mosi_nxt  = mosi;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    load_tx   = 1'b0;
    shift_tx  = 1'b0;
    sample_rx = 1'b0;
    load_rx   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          ss_nxt   = ~(3'b001 << slave_sel);
          busy_nxt = 1'b1;
          mosi_nxt = tx_data[7];
          sclk_nxt = 1'b0;
          load_tx  = 1'b1;
        end
      end
      SETUP: begin
        if (phase_end) begin
          sclk_nxt  = 1'b1;
          sample_rx = 1'b1;
        end
      end
      XFER: begin
        if (phase_end && phase != 4'd15) begin
          sclk_nxt = ~sclk;
          if (sclk) begin
            if (phase != 4'd14) begin
              mosi_nxt = tx_sr[6];
              shift_tx = 1'b1;
            end
          end else begin
            sample_rx = 1'b1;
          end
        end
      end
      HOLD: begin
        if (phase_end) begin
          ss_nxt   = 3'b111;
          busy_nxt = 1'b0;
          mosi_nxt = 1'b0;
          done_nxt = 1'b1;
          load_rx  = 1'b1;
        end
      end
      default: begin
        sclk_nxt = 1'b0;
        ss_nxt   = 3'b111;
        mosi_nxt = 1'b0;
        busy_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      phase   <= 4'd0;
      tx_sr   <= 7'd0;
      rx_sr   <= 8'd0;
      sclk    <= 1'b0;
      ss      <= 3'b111;
      mosi    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= 8'd0;
    end else begin
      sclk <= sclk_nxt;
      ss   <= ss_nxt;
      mosi <= mosi_nxt;
      busy <= busy_nxt;
      done <= done_nxt;

      if (state == IDLE || phase_end) cnt <= '0;
      else                            cnt <= cnt + CW'(1);

      if (state != XFER)  phase <= 4'd0;
      else if (phase_end) phase <= phase + 4'd1;

      // Bit 7 goes straight to mosi on accept, so only bits 6..0 are kept.
      if (load_tx)       tx_sr <= tx_data[6:0];
      else if (shift_tx) tx_sr <= {tx_sr[5:0], 1'b0};

      if (load_tx)        rx_sr <= 8'd0;
      else if (sample_rx) rx_sr <= {rx_sr[6:0], miso};

      if (load_rx) rx_data <= rx_sr;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: per-cycle waveform model at CLK_DIV=2 plus a mode-0 slave model at CLK_DIV=4.
module tb_spi_master;
  localparam int D2 = 2;
  localparam int D4 = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       start = 1'b0;
  logic [1:0] slave_sel = 2'd0;
  logic [7:0] tx_data = 8'd0;
  logic       miso;
  logic       sclk, mosi, busy, done;
  logic [2:0] ss;
  logic [7:0] rx_data;

  logic       start4 = 1'b0;
  logic [1:0] sel4 = 2'd0;
  logic [7:0] tx4 = 8'd0;
  logic       miso4 = 1'b0;
  logic       sclk4, mosi4, busy4, done4;
  logic [2:0] ss4;
  logic [7:0] rx4;

  int         miso_mode = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] rx_model = 8'h00;

  typedef struct {
    logic [7:0] tx;
    logic [1:0] sel;
    int         mode;
    logic [7:0] exp_rx;
  } vec_t;
  vec_t tbl[6];

  // miso source: 0 loopback, 1 tied low, 2 tied high, 3 inverted loopback
  assign miso = (miso_mode == 0) ? mosi :
                (miso_mode == 1) ? 1'b0 :
                (miso_mode == 2) ? 1'b1 : ~mosi;

  spi_master #(.CLK_DIV(D2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .slave_sel(slave_sel), .tx_data(tx_data),
    .miso(miso), .sclk(sclk), .ss(ss), .mosi(mosi), .rx_data(rx_data), .busy(busy), .done(done)
  );

  spi_master #(.CLK_DIV(D4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .slave_sel(sel4), .tx_data(tx4),
    .miso(miso4), .sclk(sclk4), .ss(ss4), .mosi(mosi4), .rx_data(rx4), .busy(busy4), .done(done4)
  );

  always #5 clk = ~clk;

  logic [7:0] slv_byte = 8'h3C;
  logic [7:0] slv_rx = 8'h00;
  logic [2:0] sbit = 3'd0;
  int         rises4 = 0;

  always @(negedge ss4[2]) begin
    sbit  = 3'd7;
    miso4 = slv_byte[7];
  end

  always @(negedge sclk4) begin
    if (!ss4[2] && sbit != 3'd0) begin
      sbit  = sbit - 3'd1;
      miso4 = slv_byte[sbit];
    end
  end

  always @(posedge sclk4) begin
    rises4++;
    if (!ss4[2]) slv_rx = {slv_rx[6:0], mosi4};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_rx(input logic [7:0] tx, input int mode);
    case (mode)
      0:       return tx;
      1:       return 8'h00;
      2:       return 8'hFF;
      default: return ~tx;
    endcase
  endfunction

  // Expected {sclk, ss, mosi, busy, done, rx_data} in cycle k after acceptance.
  function automatic logic [14:0] exp_out(input int k, input int d, input logic [7:0] tx,
                                          input logic [1:0] sel, input logic [7:0] rx_old,
                                          input logic [7:0] rx_new);
    logic       active, e_sclk, e_mosi, e_done;
    logic [2:0] one, e_ss;
    logic [7:0] t, e_rx;
    int         n;
    active = (k >= 1) && (k <= 18 * d);
    one    = 3'b001 << sel;
    e_ss   = active ? ~one : 3'b111;
    e_done = (k == 18 * d + 1);
    e_sclk = (k >= 1 + d) && (k < 1 + 17 * d) && ((((k - 1 - d) / d) % 2) == 0);
    n      = (k - 1) / (2 * d);
    if (n > 7) n = 7;
    t      = tx << n;
    e_mosi = active ? t[7] : 1'b0;
    e_rx   = (k >= 18 * d + 1) ? rx_new : rx_old;
    return {e_sclk, e_ss, e_mosi, active, e_done, e_rx};
  endfunction

  task automatic xfer(input logic [7:0] tx, input logic [1:0] sel, input int mode,
                      input logic [7:0] exp_rx, input int poke_k);
    logic [14:0] e;
    miso_mode = mode;
    @(posedge clk); #1;
    start = 1'b1; tx_data = tx; slave_sel = sel;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 18 * D2 + 3; k++) begin
      @(negedge clk);
      e = exp_out(k, D2, tx, sel, rx_model, exp_rx);
      check($sformatf("xfer %h sel %0d cyc %0d", tx, sel, k),
            32'({sclk, ss, mosi, busy, done, rx_data}), 32'(e));
      if (k == poke_k) begin
        start = 1'b1; tx_data = 8'h00; slave_sel = 2'd1;
      end else if (k == poke_k + 1) begin
        start = 1'b0;
      end
    end
    rx_model = exp_rx;
  endtask

  initial begin
    int dn1, dn2, extra, lowcnt, bad, donek;
    logic [7:0] rtx;
    logic [1:0] rsel;
    int rmode;
    logic [14:0] e;

    tbl[0] = '{8'hA5, 2'd0, 0, 8'hA5};
    tbl[1] = '{8'h5A, 2'd1, 1, 8'h00};
    tbl[2] = '{8'h0F, 2'd2, 2, 8'hFF};
    tbl[3] = '{8'h96, 2'd1, 3, 8'h69};
    tbl[4] = '{8'h01, 2'd2, 0, 8'h01};
    tbl[5] = '{8'h80, 2'd0, 3, 8'h7F};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset u2", 32'({sclk, ss, mosi, busy, done, rx_data}), 32'({1'b0, 3'b111, 3'b000, 8'h00}));
    check("reset u4", 32'({sclk4, ss4, mosi4, busy4, done4, rx4}), 32'({1'b0, 3'b111, 3'b000, 8'h00}));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) xfer(tbl[i].tx, tbl[i].sel, tbl[i].mode, tbl[i].exp_rx, -1);

    // start re-pulsed mid-transfer must not disturb the running transfer
    xfer(8'hC3, 2'd0, 0, 8'hC3, 10);

    // slave_sel 3 is never accepted
    @(posedge clk); #1;
    start = 1'b1; slave_sel = 2'd3; tx_data = 8'hFF;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("sel3 cyc %0d", k), 32'({sclk, ss, busy, done, rx_data}),
            32'({1'b0, 3'b111, 1'b0, 1'b0, rx_model}));
    end
    start = 1'b0;

    for (int i = 0; i < 6; i++) begin
      rtx   = 8'($urandom);
      rsel  = 2'($urandom_range(0, 2));
      rmode = int'($urandom_range(0, 3));
      xfer(rtx, rsel, rmode, model_rx(rtx, rmode), -1);
    end

    // back-to-back with start held high
    miso_mode = 0;
    @(posedge clk); #1;
    start = 1'b1; tx_data = 8'h12; slave_sel = 2'd0;
    @(posedge clk); #1;
    dn1 = 0; dn2 = 0; extra = 0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (k == 10) tx_data = 8'h34;
      if (k == 45) start = 1'b0;
      if (done) begin
        if (dn1 == 0) begin
          dn1 = k;
          check("b2b rx first", 32'(rx_data), 32'(8'h12));
        end else if (dn2 == 0) begin
          dn2 = k;
          check("b2b rx second", 32'(rx_data), 32'(8'h34));
        end else begin
          extra++;
        end
      end
      if (k == 36 || k == 38) check($sformatf("b2b ss low cyc %0d", k), 32'(ss), 32'(3'b110));
      if (k == 37) check("b2b ss gap", 32'(ss), 32'(3'b111));
    end
    check("b2b done1 cycle", 32'(dn1), 32'(37));
    check("b2b done2 cycle", 32'(dn2), 32'(74));
    check("b2b extra done", 32'(extra), 32'(0));
    rx_model = 8'h34;

    // mode-0 slave on u4, slave 2
    rises4 = 0;
    @(posedge clk); #1;
    start4 = 1'b1; sel4 = 2'd2; tx4 = 8'hFF;
    @(posedge clk); #1;
    start4 = 1'b0;
    lowcnt = 0; bad = 0; donek = 0; extra = 0;
    for (int k = 1; k <= 18 * D4 + 4; k++) begin
      @(negedge clk);
      if (ss4 == 3'b011) lowcnt++;
      if (ss4[1:0] != 2'b11) bad++;
      if (done4) begin
        if (donek == 0) begin
          donek = k;
          check("slave rx_data", 32'(rx4), 32'(8'h3C));
        end else begin
          extra++;
        end
      end
    end
    check("slave done cycle", 32'(donek), 32'(18 * D4 + 1));
    check("slave ss low cycles", 32'(lowcnt), 32'(18 * D4));
    check("slave other ss low", 32'(bad), 32'(0));
    check("slave got mosi", 32'(slv_rx), 32'(8'hFF));
    check("slave sclk rises", 32'(rises4), 32'(8));
    check("slave extra done", 32'(extra), 32'(0));

    // reset after 4 sclk rises
    miso_mode = 0;
    @(posedge clk); #1;
    start = 1'b1; tx_data = 8'h5A; slave_sel = 2'd2;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      e = exp_out(k, D2, 8'h5A, 2'd2, rx_model, 8'h5A);
      check($sformatf("pre-reset cyc %0d", k), 32'({sclk, ss, mosi, busy, done, rx_data}), 32'(e));
    end
    #1 rst_n = 1'b0;
    #1;
    check("async reset", 32'({sclk, ss, mosi, busy, done, rx_data}), 32'({1'b0, 3'b111, 3'b000, 8'h00}));
    rx_model = 8'h00;
    repeat (2) @(negedge clk);
    check("in reset no done", 32'({done, busy}), 32'(2'b00));
    rst_n = 1'b1;
    xfer(8'h81, 2'd0, 0, 8'h81, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
